vram_port_arbiter: RTL and testbench

- Shares VRAM port B (system-clock side) between NREQ pixel requesters: clear engine, line rasteriser, host pixel writes.
- Per-beat valid/ready handshake toward the requesters, with round-robin ownership.
- Each ownership is capped at MAX_BURST beats so no requester can starve the others.
- Registers the granted beat onto the VRAM port and returns read data, tagged to the issuing requester, two cycles after acceptance.

---
 rtl/vram_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_vram_port_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_port_arbiter.sv
// Round-robin, burst-capped arbiter sharing VRAM port B among NREQ pixel requesters.
// Define VRAM_ADDR_CHECK_EN to drop out-of-range beats and raise the sticky err_addr flag.
module vram_port_arbiter #(
    parameter int NREQ        = 3,
    parameter int ADDR_W      = 18,
    parameter int MAX_BURST   = 64,
    parameter int TOTAL_BYTES = 98304,
    localparam int OW         = $clog2(NREQ),
    localparam int CW         = $clog2(MAX_BURST + 1)
) (
    input  logic                   CLK,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*8-1:0]      req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rd_valid,
    output logic [7:0]             rd_data,
    output logic [ADDR_W-1:0]      vram_addr_b,
    output logic [7:0]             vram_data_b,
    output logic                   vram_we_b,
    input  logic [7:0]             vram_q_b,
    output logic [OW-1:0]          owner,
    output logic                   busy,
    output logic                   err_addr
);

    typedef enum logic {IDLE, OWN} state_t;

    state_t            r_state, w_stateNext;
    logic [OW-1:0]     r_owner, w_ownerNext;
    logic [OW-1:0]     r_rrPtr, w_rrPtrNext;
    logic [OW-1:0]     w_ownerPlus1;
    logic [CW-1:0]     r_beatCnt, w_beatCntNext;
    logic              w_ownValid, w_accept, w_lastBeat, w_release, w_forward;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_data;
    logic              w_we;
    logic              r_rdV1, r_rdV2;
    logic [OW-1:0]     r_rdId1, r_rdId2;

    // First set bit of mask, scanning start, start+1, ... modulo NREQ.
    function automatic logic [OW-1:0] pickFrom(input logic [NREQ-1:0] mask,
                                               input logic [OW-1:0]   start);
        logic [OW-1:0] res;
        logic [OW-1:0] kk;
        logic          found;
        res   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            kk = OW'((int'(start) + i) % NREQ);
            if (!found && mask[kk]) begin
                res   = kk;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign w_ownValid   = req_valid[r_owner];
    assign w_accept     = (r_state == OWN) && w_ownValid;
    assign w_lastBeat   = (r_beatCnt == CW'(MAX_BURST - 1));
    assign w_release    = (r_state == OWN) && (!w_ownValid || w_lastBeat);
    assign w_ownerPlus1 = (r_owner == OW'(NREQ - 1)) ? '0 : r_owner + OW'(1);

    assign w_addr = req_addr[r_owner*ADDR_W +: ADDR_W];
    assign w_data = req_data[r_owner*8 +: 8];
    assign w_we   = req_we[r_owner];

    assign owner = r_owner;
    assign busy  = (r_state == OWN);

    always_comb begin
        req_ready = '0;
        if (r_state == OWN) req_ready[r_owner] = w_ownValid;
    end

    // Release re-arbitrates on the same edge so a waiting requester takes over with no idle bubble.
    always_comb begin
        w_stateNext   = r_state;
        w_ownerNext   = r_owner;
        w_rrPtrNext   = r_rrPtr;
        w_beatCntNext = r_beatCnt;
        case (r_state)
            IDLE: begin
                if (|req_valid) begin
                    w_ownerNext   = pickFrom(req_valid, r_rrPtr);
                    w_beatCntNext = '0;
                    w_stateNext   = OWN;
                end
            end
            OWN: begin
                if (w_accept) w_beatCntNext = r_beatCnt + CW'(1);
                if (w_release) begin
                    w_rrPtrNext = w_ownerPlus1;
                    if (|req_valid) begin
                        w_ownerNext   = pickFrom(req_valid, w_ownerPlus1);
                        w_beatCntNext = '0;
                    end else begin
                        w_stateNext = IDLE;
                    end
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_owner   <= '0;
            r_rrPtr   <= '0;
            r_beatCnt <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_owner   <= w_ownerNext;
            r_rrPtr   <= w_rrPtrNext;
            r_beatCnt <= w_beatCntNext;
        end
    end

`ifdef VRAM_ADDR_CHECK_EN
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(TOTAL_BYTES);

    logic w_inRange;
    logic r_oob1, r_oob2, r_err;

    assign w_inRange = ({1'b0, w_addr} < LIMIT);
    assign w_forward = w_accept && w_inRange;
    assign err_addr  = r_err;
    assign rd_data   = (r_rdV2 && !r_oob2) ? vram_q_b : 8'h00;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_oob1 <= 1'b0;
            r_oob2 <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_oob1 <= w_accept && !w_inRange;
            r_oob2 <= r_oob1;
            if (w_accept && !w_inRange) r_err <= 1'b1;
        end
    end
`else
    assign w_forward = w_accept;
    assign err_addr  = 1'b0;
    assign rd_data   = r_rdV2 ? vram_q_b : 8'h00;
`endif

    // Two-stage {valid, id} tag pipeline lines the return up with the RAM's one-cycle read latency.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            vram_addr_b <= '0;
            vram_data_b <= '0;
            vram_we_b   <= 1'b0;
            r_rdV1      <= 1'b0;
            r_rdV2      <= 1'b0;
            r_rdId1     <= '0;
            r_rdId2     <= '0;
        end else begin
            vram_we_b <= w_forward && w_we;
            if (w_forward) begin
                vram_addr_b <= w_addr;
                vram_data_b <= w_data;
            end
            r_rdV1  <= w_accept && !w_we;
            r_rdId1 <= r_owner;
            r_rdV2  <= r_rdV1;
            r_rdId2 <= r_rdId1;
        end
    end

    always_comb begin
        rd_valid = '0;
        if (r_rdV2) rd_valid[r_rdId2] = 1'b1;
    end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Self-checking bench for vram_port_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model of the arbitration and VRAM rules.
module tb_vram_port_arbiter;

    localparam int NREQ  = 3;
    localparam int AW    = 18;
    localparam int MAXB  = 4;
    localparam int TOTAL = 98304;

    logic          CLK;
    logic          rst_n;
    logic [2:0]    req_valid, req_we, req_ready, rd_valid;
    logic [53:0]   req_addr;
    logic [23:0]   req_data;
    logic [7:0]    rd_data, vram_data_b, vram_q_b;
    logic [AW-1:0] vram_addr_b;
    logic          vram_we_b, busy, err_addr;
    logic [1:0]    owner;

    vram_port_arbiter #(
        .NREQ(NREQ), .ADDR_W(AW), .MAX_BURST(MAXB), .TOTAL_BYTES(TOTAL)
    ) dut (
        .CLK(CLK), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .vram_addr_b(vram_addr_b), .vram_data_b(vram_data_b), .vram_we_b(vram_we_b),
        .vram_q_b(vram_q_b), .owner(owner), .busy(busy), .err_addr(err_addr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // VRAM port B: synchronous write, one-cycle registered read.
    logic [7:0] vmem [0:1023];
    always @(posedge CLK) begin
        if (vram_we_b) vmem[vram_addr_b[9:0]] <= vram_data_b;
        vram_q_b <= vmem[vram_addr_b[9:0]];
    end

    int nPass, nTotal;

    // Reference model state
    logic [7:0] refMem [0:1023];
    int mBusy, mOwner, mPtr, mCnt;
    logic          eWe, eErr;
    logic [AW-1:0] eAddr;
    logic [7:0]    eData;
    int p1Id, p2Id;
    logic [7:0] p1Data, p2Data;

    // Expected outputs for the current cycle
    logic [2:0] xReady, xRdValid;
    logic [7:0] xRdData;

    function automatic int scanFrom(input logic [2:0] v, input int start);
        for (int i = 0; i < NREQ; i++)
            if (v[(start + i) % NREQ]) return (start + i) % NREQ;
        return -1;
    endfunction

    task automatic resetModel();
        mBusy = 0; mOwner = 0; mPtr = 0; mCnt = 0;
        eWe = 1'b0; eErr = 1'b0; eAddr = '0; eData = 8'h00;
        p1Id = -1; p2Id = -1; p1Data = 8'h00; p2Data = 8'h00;
    endtask

    task automatic clearInputs();
        req_valid = '0; req_we = '0; req_addr = '0; req_data = '0;
    endtask

    task automatic setReq(input int i, input logic v, input logic we, input int addr, input logic [7:0] d);
        req_valid[i]          = v;
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = AW'(addr);
        req_data[i*8 +: 8]    = d;
    endtask

    task automatic sample();
        #1;
        xReady = '0;
        if (mBusy != 0 && req_valid[mOwner]) xReady[mOwner] = 1'b1;
        xRdValid = '0;
        xRdData  = 8'h00;
        if (p2Id >= 0) begin
            xRdValid[p2Id] = 1'b1;
            xRdData        = p2Data;
        end
    endtask

    // Advance the model by one clock using this cycle's inputs, then move to the next negedge.
    task automatic commit();
        int acc, id, a, w;
        logic we, oob;
        acc = (mBusy != 0 && req_valid[mOwner]) ? 1 : 0;
        id  = mOwner;
        p2Id = p1Id; p2Data = p1Data; p1Id = -1;
        eWe = 1'b0;
        if (acc != 0) begin
            a   = int'(req_addr[id*AW +: AW]);
            we  = req_we[id];
            oob = 1'b0;
`ifdef VRAM_ADDR_CHECK_EN
            oob = (a >= TOTAL);
            if (oob) eErr = 1'b1;
`endif
            if (!oob) begin
                eWe   = we;
                eAddr = AW'(a);
                eData = req_data[id*8 +: 8];
                if (we) refMem[a % 1024] = eData;
            end
            if (!we) begin
                p1Id   = id;
                p1Data = oob ? 8'h00 : refMem[a % 1024];
            end
            mCnt++;
        end
        if (mBusy != 0) begin
            if (!req_valid[mOwner] || mCnt == MAXB) begin
                mPtr = (mOwner + 1) % NREQ;
                w    = scanFrom(req_valid, mPtr);
                if (w >= 0) begin
                    mOwner = w;
                    mCnt   = 0;
                end else begin
                    mBusy = 0;
                end
            end
        end else if (req_valid != 3'b000) begin
            mOwner = scanFrom(req_valid, mPtr);
            mBusy  = 1;
            mCnt   = 0;
        end
        @(negedge CLK);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        clearInputs();
        resetModel();
        @(negedge CLK);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clearInputs();
        resetModel();
        @(negedge CLK);
        #1;
        nTotal++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b, expected 0", busy); else nPass++;
        nTotal++; if (req_ready !== 3'b000) $display("[TB] FAIL reset_ready: got %b, expected 000", req_ready); else nPass++;
        nTotal++; if (rd_valid !== 3'b000) $display("[TB] FAIL reset_rd_valid: got %b, expected 000", rd_valid); else nPass++;
        nTotal++; if (rd_data !== 8'h00) $display("[TB] FAIL reset_rd_data: got %h, expected 00", rd_data); else nPass++;
        nTotal++; if (vram_addr_b !== '0) $display("[TB] FAIL reset_addr: got %h, expected 0", vram_addr_b); else nPass++;
        nTotal++; if (vram_data_b !== 8'h00) $display("[TB] FAIL reset_data: got %h, expected 00", vram_data_b); else nPass++;
        nTotal++; if (vram_we_b !== 1'b0) $display("[TB] FAIL reset_we: got %b, expected 0", vram_we_b); else nPass++;
        nTotal++; if (err_addr !== 1'b0) $display("[TB] FAIL reset_err: got %b, expected 0", err_addr); else nPass++;
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            sample();
            nTotal++; if (busy !== 1'b0) $display("[TB] FAIL idle_busy c%0d: got %b, expected 0", c, busy); else nPass++;
            nTotal++; if (vram_we_b !== 1'b0) $display("[TB] FAIL idle_we c%0d: got %b, expected 0", c, vram_we_b); else nPass++;
            nTotal++; if (req_ready !== 3'b000) $display("[TB] FAIL idle_ready c%0d: got %b, expected 000", c, req_ready); else nPass++;
            commit();
        end
    endtask

    task automatic test_write_burst();
        int sent, pulses;
        sent = 0; pulses = 0;
        for (int c = 0; c < 12; c++) begin
            if (sent < 5) setReq(0, 1'b1, 1'b1, sent, 8'(8'h11 + sent));
            else clearInputs();
            sample();
            if (c == 1) begin
                nTotal++; if (req_ready !== 3'b001) $display("[TB] FAIL wr_first_ready: got %b, expected 001", req_ready); else nPass++;
            end
            nTotal++; if (req_ready !== xReady) $display("[TB] FAIL wr_ready c%0d: got %b, expected %b", c, req_ready, xReady); else nPass++;
            nTotal++; if (vram_we_b !== eWe) $display("[TB] FAIL wr_we c%0d: got %b, expected %b", c, vram_we_b, eWe); else nPass++;
            if (eWe) begin
                pulses++;
                nTotal++; if (vram_addr_b !== eAddr) $display("[TB] FAIL wr_addr c%0d: got %h, expected %h", c, vram_addr_b, eAddr); else nPass++;
                nTotal++; if (vram_data_b !== eData) $display("[TB] FAIL wr_data c%0d: got %h, expected %h", c, vram_data_b, eData); else nPass++;
            end
            if (xReady[0]) sent++;
            commit();
        end
        sample();
        nTotal++; if (pulses != 5) $display("[TB] FAIL wr_pulse_count: got %0d, expected 5", pulses); else nPass++;
        nTotal++; if (busy !== 1'b0) $display("[TB] FAIL wr_end_busy: got %b, expected 0", busy); else nPass++;
        commit();
    endtask

    task automatic test_burst_rotation();
        logic [2:0] expR;
        doReset();
        for (int c = 0; c < 17; c++) begin
            setReq(0, 1'b1, 1'b1, $urandom_range(0, 255), 8'($urandom));
            setReq(2, 1'b1, 1'b1, $urandom_range(0, 255), 8'($urandom));
            sample();
            if (c == 0) expR = 3'b000;
            else expR = (((c - 1) / MAXB) % 2 == 0) ? 3'b001 : 3'b100;
            nTotal++; if (req_ready !== expR) $display("[TB] FAIL rot_ready c%0d: got %b, expected %b", c, req_ready, expR); else nPass++;
            nTotal++; if (vram_we_b !== eWe) $display("[TB] FAIL rot_we c%0d: got %b, expected %b", c, vram_we_b, eWe); else nPass++;
            if (c >= 1) begin
                nTotal++; if (busy !== 1'b1) $display("[TB] FAIL rot_busy c%0d: got %b, expected 1", c, busy); else nPass++;
            end
            commit();
        end
        clearInputs();
        for (int c = 0; c < 2; c++) begin sample(); commit(); end
    endtask

    task automatic test_read_return();
        int wsent, rsent, firstAcc, k;
        logic [2:0] expV;
        wsent = 0; rsent = 0; firstAcc = -1;
        for (int c = 0; c < 8 && wsent < 3; c++) begin
            setReq(1, 1'b1, 1'b1, 100 + wsent, 8'(8'hA0 + wsent));
            sample();
            nTotal++; if (req_ready !== xReady) $display("[TB] FAIL rdw_ready c%0d: got %b, expected %b", c, req_ready, xReady); else nPass++;
            if (xReady[1]) wsent++;
            commit();
        end
        nTotal++; if (wsent != 3) $display("[TB] FAIL rdw_count: got %0d, expected 3", wsent); else nPass++;
        clearInputs();
        sample(); commit();
        for (int c = 0; c < 10; c++) begin
            if (rsent < 3) setReq(1, 1'b1, 1'b0, 100 + rsent, 8'h00);
            else clearInputs();
            sample();
            k = (firstAcc >= 0) ? c - firstAcc - 2 : -1;
            expV = (k >= 0 && k < 3) ? 3'b010 : 3'b000;
            nTotal++; if (rd_valid !== expV) $display("[TB] FAIL rd_valid c%0d: got %b, expected %b", c, rd_valid, expV); else nPass++;
            if (k >= 0 && k < 3) begin
                nTotal++; if (rd_data !== 8'(8'hA0 + k)) $display("[TB] FAIL rd_data c%0d: got %h, expected %h", c, rd_data, 8'(8'hA0 + k)); else nPass++;
            end
            if (xReady[1]) begin
                if (firstAcc < 0) firstAcc = c;
                rsent++;
            end
            commit();
        end
    endtask

    task automatic test_reset_flush();
        clearInputs();
        setReq(1, 1'b1, 1'b0, 101, 8'h00);
        sample(); commit();
        sample();
        nTotal++; if (req_ready !== 3'b010) $display("[TB] FAIL flush_accept: got %b, expected 010", req_ready); else nPass++;
        commit();
        rst_n = 1'b0;
        clearInputs();
        resetModel();
        #1;
        nTotal++; if (rd_valid !== 3'b000) $display("[TB] FAIL flush_rd_in_reset: got %b, expected 000", rd_valid); else nPass++;
        @(negedge CLK);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            sample();
            nTotal++; if (rd_valid !== 3'b000) $display("[TB] FAIL flush_rd c%0d: got %b, expected 000", c, rd_valid); else nPass++;
            nTotal++; if (busy !== 1'b0) $display("[TB] FAIL flush_busy c%0d: got %b, expected 0", c, busy); else nPass++;
            commit();
        end
        for (int i = 0; i < NREQ; i++) setReq(i, 1'b1, 1'b1, 200 + i, 8'(8'h30 + i));
        sample(); commit();
        sample();
        nTotal++; if (req_ready !== 3'b001) $display("[TB] FAIL flush_ptr_ready: got %b, expected 001", req_ready); else nPass++;
        nTotal++; if (owner !== 2'd0) $display("[TB] FAIL flush_ptr_owner: got %0d, expected 0", owner); else nPass++;
        commit();
        clearInputs();
        for (int c = 0; c < 3; c++) begin sample(); commit(); end
    endtask

    task automatic test_addr_check();
        doReset();
        setReq(2, 1'b1, 1'b1, TOTAL, 8'h5A);
        sample(); commit();
        sample();
        nTotal++; if (req_ready !== 3'b100) $display("[TB] FAIL oob_ready: got %b, expected 100", req_ready); else nPass++;
        commit();
        clearInputs();
        sample();
`ifdef VRAM_ADDR_CHECK_EN
        nTotal++; if (vram_we_b !== 1'b0) $display("[TB] FAIL oob_we: got %b, expected 0", vram_we_b); else nPass++;
        nTotal++; if (vram_addr_b !== '0) $display("[TB] FAIL oob_addr: got %h, expected 0", vram_addr_b); else nPass++;
        nTotal++; if (err_addr !== 1'b1) $display("[TB] FAIL oob_err: got %b, expected 1", err_addr); else nPass++;
`else
        nTotal++; if (vram_we_b !== 1'b1) $display("[TB] FAIL oob_we: got %b, expected 1", vram_we_b); else nPass++;
        nTotal++; if (vram_addr_b !== AW'(TOTAL)) $display("[TB] FAIL oob_addr: got %h, expected %h", vram_addr_b, AW'(TOTAL)); else nPass++;
        nTotal++; if (err_addr !== 1'b0) $display("[TB] FAIL oob_err: got %b, expected 0", err_addr); else nPass++;
`endif
        commit();
        for (int c = 0; c < 3; c++) begin
            sample();
            nTotal++; if (err_addr !== eErr) $display("[TB] FAIL oob_err_hold c%0d: got %b, expected %b", c, err_addr, eErr); else nPass++;
            commit();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++)
                setReq(i, ($urandom_range(0, 99) < 60), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 255), 8'($urandom));
            sample();
            nTotal++; if (req_ready !== xReady) $display("[TB] FAIL rnd_ready c%0d: got %b, expected %b", c, req_ready, xReady); else nPass++;
            nTotal++; if (busy !== (mBusy != 0)) $display("[TB] FAIL rnd_busy c%0d: got %b, expected %0d", c, busy, mBusy); else nPass++;
            if (mBusy != 0) begin
                nTotal++; if (owner !== 2'(mOwner)) $display("[TB] FAIL rnd_owner c%0d: got %0d, expected %0d", c, owner, mOwner); else nPass++;
            end
            nTotal++; if (vram_we_b !== eWe) $display("[TB] FAIL rnd_we c%0d: got %b, expected %b", c, vram_we_b, eWe); else nPass++;
            nTotal++; if (vram_addr_b !== eAddr) $display("[TB] FAIL rnd_addr c%0d: got %h, expected %h", c, vram_addr_b, eAddr); else nPass++;
            nTotal++; if (vram_data_b !== eData) $display("[TB] FAIL rnd_data c%0d: got %h, expected %h", c, vram_data_b, eData); else nPass++;
            nTotal++; if (rd_valid !== xRdValid) $display("[TB] FAIL rnd_rd_valid c%0d: got %b, expected %b", c, rd_valid, xRdValid); else nPass++;
            if (xRdValid != 3'b000) begin
                nTotal++; if (rd_data !== xRdData) $display("[TB] FAIL rnd_rd_data c%0d: got %h, expected %h", c, rd_data, xRdData); else nPass++;
            end
            nTotal++; if (err_addr !== eErr) $display("[TB] FAIL rnd_err c%0d: got %b, expected %b", c, err_addr, eErr); else nPass++;
            commit();
        end
    endtask

    initial begin
        nPass = 0;
        nTotal = 0;
        for (int i = 0; i < 1024; i++) begin
            vmem[i]   = 8'(i * 7 + 3);
            refMem[i] = 8'(i * 7 + 3);
        end
        test_reset();
        test_write_burst();
        test_burst_rotation();
        test_read_return();
        test_reset_flush();
        test_addr_check();
        test_random();
        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
